// File: rtl/fsm_seq_pkg.sv
// rtl/fsm_seq_pkg.sv - shared state encoding and pattern constant for the 1101 generator/detector pair
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [3:0] PATTERN_1101 = 4'b1101;

endpackage

// File: rtl/seq_gen_1101.sv
// rtl/seq_gen_1101.sv - bit-serial repeated-pattern transmitter with optional zero gaps
module seq_gen_1101
  import fsm_seq_pkg::*;
#(
  parameter int                 PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PATTERN = PATTERN_1101,
  parameter int                 REP_W   = 8,
  parameter int                 GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] sent_cnt
);

  localparam int               IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_t           r_state, w_state;
  logic [IDX_W-1:0] r_idx,   w_idx;
  logic [GAP_W-1:0] r_gcnt,  w_gcnt;
  logic [REP_W-1:0] r_reps,  w_reps;
  logic [GAP_W-1:0] r_gap,   w_gap;
  logic [REP_W-1:0] r_sent,  w_sent;
  logic             r_out,   w_out;
  logic             r_valid, w_valid;
  logic             r_busy,  w_busy;
  logic             r_done,  w_done;
  logic             w_last_rep;

  // reps is never zero outside IDLE, so reps-1 cannot underflow; this avoids a wider compare
  assign w_last_rep = (r_sent == (r_reps - REP_ONE));

  // next-state and next-output decode; every register's next value has a default
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_gcnt  = r_gcnt;
    w_reps  = r_reps;
    w_gap   = r_gap;
    w_sent  = r_sent;
    w_out   = 1'b0;
    w_valid = 1'b0;
    w_busy  = r_busy;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_reps = reps;
          w_gap  = gap;
          w_sent = '0;
          w_busy = 1'b1;
          if (reps != '0) begin
            w_state = S_SEND;
            w_idx   = IDX_TOP;
            w_out   = PATTERN[PAT_W-1];
            w_valid = 1'b1;
          end else begin
            w_state = S_FIN;
            w_done  = 1'b1;
          end
        end
      end
      S_SEND: begin
        w_valid = 1'b1;
        if (r_idx != '0) begin
          w_idx = r_idx - IDX_ONE;
          w_out = PATTERN[r_idx - IDX_ONE];
        end else begin
          w_sent = r_sent + REP_ONE;
          if (w_last_rep) begin
            w_state = S_FIN;
            w_valid = 1'b0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end else if (r_gap != '0) begin
            w_state = S_GAP;
            w_gcnt  = r_gap;
          end else begin
            w_idx = IDX_TOP;
            w_out = PATTERN[PAT_W-1];
          end
        end
      end
      S_GAP: begin
        w_valid = 1'b1;
        if (r_gcnt == GAP_ONE) begin
          w_state = S_SEND;
          w_idx   = IDX_TOP;
          w_out   = PATTERN[PAT_W-1];
        end else begin
          w_gcnt = r_gcnt - GAP_ONE;
        end
      end
      S_FIN: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  // state and datapath registers; reset aborts any command without a done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_gcnt  <= '0;
      r_reps  <= '0;
      r_gap   <= '0;
      r_sent  <= '0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_gcnt  <= w_gcnt;
      r_reps  <= w_reps;
      r_gap   <= w_gap;
      r_sent  <= w_sent;
      r_out   <= w_out;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign out      = r_out;
  assign valid    = r_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign sent_cnt = r_sent;

endmodule

// File: tb/tb_seq_gen_1101.sv
// tb/tb_seq_gen_1101.sv - directed self-checking bench for seq_gen_1101
module tb_seq_gen_1101;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] reps = 8'd0;
  logic [3:0] gap = 4'd0;
  logic       out;
  logic       valid;
  logic       busy;
  logic       done;
  logic [7:0] sent_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int det;

  seq_gen_1101 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .reps     (reps),
    .gap      (gap),
    .out      (out),
    .valid    (valid),
    .busy     (busy),
    .done     (done),
    .sent_cnt (sent_cnt)
  );

  // free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_out, input logic e_valid,
                         input logic e_busy, input logic e_done, input logic [7:0] e_sent);
    chk({tag, "/out"},   {31'd0, out},   {31'd0, e_out});
    chk({tag, "/valid"}, {31'd0, valid}, {31'd0, e_valid});
    chk({tag, "/busy"},  {31'd0, busy},  {31'd0, e_busy});
    chk({tag, "/done"},  {31'd0, done},  {31'd0, e_done});
    chk({tag, "/sent"},  {24'd0, sent_cnt}, {24'd0, e_sent});
  endtask

  // Issues one command from a negedge and checks every cycle against a reference
  // stream built here; returns the number of non-overlapping 1101 hits seen on valid bits.
  task automatic run_cmd(input string tag, input logic [7:0] n_reps, input logic [3:0] n_gap,
                         input bit disturb, output int hits);
    bit         q_bits[$];
    bit         q_last[$];
    logic [3:0] pat;
    logic [3:0] shreg;
    logic [7:0] e_sent;
    pat   = 4'b1101;
    hits  = 0;
    shreg = 4'd0;
    for (int r = 0; r < int'(n_reps); r++) begin
      for (int b = 3; b >= 0; b--) begin
        q_bits.push_back(pat[b]);
        q_last.push_back(b == 0);
      end
      if (r < int'(n_reps) - 1) begin
        for (int g = 0; g < int'(n_gap); g++) begin
          q_bits.push_back(1'b0);
          q_last.push_back(1'b0);
        end
      end
    end
    start = 1'b1;
    reps  = n_reps;
    gap   = n_gap;
    tick();
    start = 1'b0;
    if (n_reps == 8'd0) begin
      chk_all({tag, "/zero_fin"}, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
      tick();
      chk_all({tag, "/zero_idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      return;
    end
    e_sent = 8'd0;
    for (int i = 0; i < q_bits.size(); i++) begin
      chk_all($sformatf("%s/c%0d", tag, i + 1), q_bits[i], 1'b1, 1'b1, 1'b0, e_sent);
      shreg = {shreg[2:0], out};
      if (shreg == 4'b1101) begin
        hits++;
        shreg = 4'd0;
      end
      if (q_last[i]) e_sent = e_sent + 8'd1;
      if (disturb && i == 1) begin
        start = 1'b1;
        reps  = ~n_reps;
        gap   = ~n_gap;
      end
      if (disturb && i == q_bits.size() - 1) start = 1'b0;
      tick();
    end
    chk_all({tag, "/done"}, 1'b0, 1'b0, 1'b0, 1'b1, n_reps);
    tick();
    chk_all({tag, "/after"}, 1'b0, 1'b0, 1'b0, 1'b0, n_reps);
  endtask

  // directed sequence
  initial begin
    #2;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    run_cmd("r1g0", 8'd1, 4'd0, 1'b0, det);
    chk("r1g0/hits", det, 1);

    run_cmd("r3g0", 8'd3, 4'd0, 1'b0, det);
    chk("r3g0/hits", det, 3);

    run_cmd("r2g2", 8'd2, 4'd2, 1'b0, det);
    chk("r2g2/hits", det, 2);

    run_cmd("r0", 8'd0, 4'd5, 1'b0, det);

    run_cmd("dist", 8'd2, 4'd1, 1'b1, det);
    chk("dist/hits", det, 2);
    reps = 8'd0;
    gap  = 4'd0;

    run_cmd("r2g15", 8'd2, 4'd15, 1'b0, det);
    chk("r2g15/hits", det, 2);

    run_cmd("r255", 8'd255, 4'd0, 1'b0, det);
    chk("r255/hits", det, 255);

    // abort during second repetition: cycles 1-4 first pattern, 5 gap, 6-9 second pattern
    start = 1'b1;
    reps  = 8'd3;
    gap   = 4'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk_all("abort/pre", 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_all("abort/async", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    chk_all("abort/held", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b1;
    tick();
    chk_all("abort/idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    run_cmd("post", 8'd1, 4'd0, 1'b0, det);
    chk("post/hits", det, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_gen_1101.md
Name: seq_gen_1101

Overview:
- Bit-serial pattern transmitter: the sending end for the team's "1101" sequence detectors.
- On command, emits a fixed PAT_W-bit pattern MSB-first, repeated a programmed number of times, with an optional run of idle '0' gap bits between repetitions.
- Drives detector testbenches and on-chip self-test of the serial input path.
- One bit per clock. Start/busy/done handshake toward the controlling logic.

Parameters:
- PAT_W, 4: pattern length in bits (>=2).
- PATTERN, 4'b1101: pattern value; bit PAT_W-1 is transmitted first.
- REP_W, 8: width of the repetition count.
- GAP_W, 4: width of the gap-length field.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  command strobe; sampled only in IDLE.
- reps  in  REP_W  number of pattern repetitions; latched on accepted start.
- gap  in  GAP_W  number of '0' bits between repetitions; latched on accepted start.
- out  out  1  serial data bit (registered).
- valid  out  1  high while out carries a pattern or gap bit (registered).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final bit.
- sent_cnt  out  REP_W  completed repetitions in the current or last command.

Behaviour:
- Reset (rst=0, async): state=IDLE; out=0, valid=0, busy=0, done=0, sent_cnt=0. All internal counters are cleared. Reset mid-transmission aborts immediately with no done pulse.
- States: IDLE, SEND, GAP, FIN.
- IDLE:
  - start=1, reps!=0: latch reps/gap; sent_cnt<=0, bit index<=PAT_W-1; go to SEND. On the same edge, out<=PATTERN[PAT_W-1], valid<=1, busy<=1. First bit is visible 1 cycle after start.
  - start=1, reps=0: go to FIN with no bits sent (valid stays 0) and busy<=1.
  - start=0: out=0, valid=0.
- SEND: each cycle emit PATTERN[idx] and decrement idx. When the last bit (idx=0) is on out:
  - sent_cnt increments on that edge.
  - If sent_cnt+1 == reps, go to FIN.
  - Else if gap!=0, go to GAP with gap counter=gap.
  - Else go back to SEND at idx=PAT_W-1. The next pattern starts the very next cycle, so back-to-back patterns have no gap.
- GAP: out=0, valid=1 for exactly gap cycles. Then reload idx=PAT_W-1 and return to SEND.
- FIN: for one cycle, done=1, busy<=0, out=0, valid=0. Next state is IDLE. sent_cnt holds its value until the next accepted start.
- start while busy (SEND/GAP/FIN) is ignored. Latched reps/gap are unaffected by later input changes.
- Per command: total valid cycles = reps*PAT_W + (reps-1)*gap. done arrives 1 cycle after the last valid bit.
- Counters are unsigned. reps = 2^REP_W-1 must work without wrap; sent_cnt never wraps within a command.
- A new start is accepted in IDLE the cycle after done (FIN -> IDLE). There is no start acceptance in FIN itself.

Decomposition:
- Shared package (fsm_seq_pkg): state encoding constants S_IDLE/S_SEND/S_GAP/S_FIN (2 bits) and the default pattern constant 4'b1101. Detector and generator use the same pattern constant.
- No sub-module needed: single FSM plus bit-index, gap and repetition counters. The bench instantiates this block driving the existing non-overlapping 1101 detector for end-to-end checks.

Test Plan:
- Reset then start=1, reps=1, gap=0 -> out sequence 1,1,0,1 with valid=1 on cycles 1-4; done=1 on cycle 5; sent_cnt=1; busy low from cycle 5 on.
- reps=3, gap=0 -> 12 valid bits 110111011101; done on cycle 13. The non-overlapping detector pulses exactly 3 times.
- reps=2, gap=2 -> valid bits 1101 00 1101 (10 cycles); done on cycle 11; sent_cnt=2.
- reps=0 -> valid never asserts; done pulses 1 cycle after the start cycle; sent_cnt=0.
- start re-asserted during SEND, and reps/gap changed mid-command -> output stream identical to the undisturbed run.
- rst driven low asynchronously (between clock edges) during 2nd repetition -> out/valid/busy/done/sent_cnt go 0 immediately with no done pulse. After release, a fresh start with reps=1 produces 1101 normally.
